e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit that owns the HI and LO registers. It accepts mult/multu/div/divu/mthi/mtlo requests from the E stage using the forwarded rs/rt operands. It models fixed multi-cycle latency with a busy handshake that the hazard unit uses to stall. It drives the `hi`/`lo` values that the E-stage read mux selects for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range ≥ 1.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mrs_E`  in  32  forwarded rs operand: dividend, multiplicand, or mthi/mtlo source.
- `mrt_E`  in  32  forwarded rt operand: divisor or multiplier.
- `md_op`  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none). Codes are defined as `MD_*` macros in const.v.
- `start`  in  1  qualifies `md_op` this cycle; E-stage instruction valid and not flushed.
- `busy`  out  1  high while a mult/div is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter `cnt` active).
- Accept rule: a request is accepted only when `start`=1, `busy`=0, and `md_op`≠0/7.
- IDLE, accept of mult/multu/div/divu:
  - Compute the 64-bit result from the current operands.
  - Store it in internal `res_hi`/`res_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES, then go to RUN.
  - `hi`/`lo` are unchanged at this edge.
- RUN, each edge: `cnt` decrements. At the edge where `cnt`==1:
  - `hi`←`res_hi` and `lo`←`res_lo`.
  - `cnt`←0 and the state returns to IDLE.
- IDLE, accept of mthi: `hi`←`mrs_E` at that edge; `lo` unchanged; no busy.
- IDLE, accept of mtlo: `lo`←`mrs_E` at that edge; `hi` unchanged; no busy.
- Any `start` while busy=1 is ignored, including mthi/mtlo. The hazard unit guarantees this does not happen; the block must still not corrupt state if it does.
- Arithmetic:
  - mult: {hi,lo} = signed 32×32 → 64.
  - multu: {hi,lo} = unsigned 32×32 → 64.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0x00000000.
- Divide by zero (div or divu, `mrt_E`=0):
  - Full DIV_CYCLES busy period still runs.
  - At completion, `hi`/`lo` retain their pre-instruction values; no write occurs.
- Operands are sampled only at the accept edge. Changes on `mrs_E`/`mrt_E` during RUN have no effect.
- Reset value of every output, and behaviour on reset assertion:
  - Reset forces `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE, and `res_hi`/`res_lo`=0.
  - Reset mid-RUN aborts the operation and discards its result.

## Timing
- `busy` is registered. It rises in the cycle after the accept edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- `hi`/`lo` show the new result in the same cycle in which `busy` first reads 0 again.
- Sequence for MULT_CYCLES=5 with accept at edge 0:
  - `busy`=1 during cycles 1–5.
  - Result written at edge 5.
  - `busy`=0 and new `hi`/`lo` visible from cycle 6.
  - A new `start` is accepted at edge 6 at the earliest.
- mthi/mtlo: zero busy cycles. The written value is visible in the cycle after the accept edge.
- Back-to-back mthi then mtlo on consecutive cycles: both are accepted; each writes its own register.
- Hazard interface: the stall unit stalls D whenever (`busy` | (`start` & `md_op`∈{1..4})) and the D instruction uses the MDU. The block itself produces only `busy`.
- No combinational path from any input to `busy`, `hi`, or `lo`.

## Test plan
- Reset and mthi:
  - Stimulus: assert `reset`=0 mid-sim, release, then apply mthi with `mrs_E`=0x12345678.
  - Required: `hi`=`lo`=`busy`=0 during reset; then `hi`=0x12345678, `lo`=0, and `busy` never asserted.
- mult/multu:
  - Stimulus: mult with `mrs_E`=0xFFFFFFFF, `mrt_E`=2.
  - Required: `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - Stimulus: multu with the same operands.
  - Required: `hi`=0x00000001, `lo`=0xFFFFFFFE.
- div/divu:
  - Stimulus: div with 0xFFFFFFF9 (−7) / 2.
  - Required: `busy` high for 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Stimulus: divu 7 / 2.
  - Required: `lo`=3, `hi`=1.
- Divide by zero and overflow:
  - Stimulus: preload `hi`=0xAAAA0000 and `lo`=0x5555FFFF, then div by 0.
  - Required: 10 busy cycles; then `hi`/`lo` unchanged.
  - Stimulus: 0x80000000 / 0xFFFFFFFF (signed).
  - Required: `lo`=0x80000000, `hi`=0.
- Ignore while busy:
  - Stimulus: start a mult, then on busy cycle 2 apply `start`=1 with mtlo 0xDEADBEEF and with divu.
  - Required: both ignored; the mult result lands on schedule; `lo`≠0xDEADBEEF.
- Reset mid-operation:
  - Stimulus: start a div, then assert `reset` on busy cycle 4 for one cycle.
  - Required: `busy`=0 and `hi`=`lo`=0 immediately; no later write; the next mult is accepted normally.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO. Multiply/divide results are
// computed at accept and committed after a fixed busy period; mthi/mtlo write at once.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mrs_E,
  input  logic [31:0] mrt_E,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] res_hi, res_hi_d, res_lo, res_lo_d;
  logic        res_wr, res_wr_d;
  logic [31:0] hi_d, lo_d;

  // Sign-extended operands: the low 64 bits of the product are the signed result.
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, quo_s, rem_s, quo_u, rem_u;
  logic        div_ovf;

  assign prod_s  = {{32{mrs_E[31]}}, mrs_E} * {{32{mrt_E[31]}}, mrt_E};
  assign prod_u  = {32'd0, mrs_E} * {32'd0, mrt_E};
  assign div_b   = (mrt_E == 32'd0) ? 32'd1 : mrt_E;
  assign div_ovf = (mrs_E == 32'h8000_0000) && (mrt_E == 32'hFFFF_FFFF);
  assign quo_s   = div_ovf ? 32'h8000_0000 : 32'($signed(mrs_E) / $signed(div_b));
  assign rem_s   = div_ovf ? 32'd0 : 32'($signed(mrs_E) % $signed(div_b));
  assign quo_u   = mrs_E / div_b;
  assign rem_u   = mrs_E % div_b;

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      res_hi <= res_hi_d;
      res_lo <= res_lo_d;
      res_wr <= res_wr_d;
      hi     <= hi_d;
      lo     <= lo_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    res_hi_d = res_hi;
    res_lo_d = res_lo;
    res_wr_d = res_wr;
    hi_d     = hi;
    lo_d     = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              res_wr_d = 1'b1;
              cnt_d    = 32'(MULT_CYCLES);
              state_d  = RUN;
            end
            MD_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              res_wr_d = 1'b1;
              cnt_d    = 32'(MULT_CYCLES);
              state_d  = RUN;
            end
            MD_DIV: begin
              res_hi_d = rem_s;
              res_lo_d = quo_s;
              res_wr_d = (mrt_E != 32'd0);
              cnt_d    = 32'(DIV_CYCLES);
              state_d  = RUN;
            end
            MD_DIVU: begin
              res_hi_d = rem_u;
              res_lo_d = quo_u;
              res_wr_d = (mrt_E != 32'd0);
              cnt_d    = 32'(DIV_CYCLES);
              state_d  = RUN;
            end
            MD_MTHI: hi_d = mrs_E;
            MD_MTLO: lo_d = mrs_E;
            default: ;
          endcase
        end
      end
      RUN: begin
        // A divide by zero still runs the full period but never commits.
        if (cnt == 32'd1) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, busy timing, divide by zero,
// ignored requests while busy, and reset in the middle of an operation.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] mrs_E;
  logic [31:0] mrt_E;
  logic [2:0]  md_op;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  int n;
  logic [31:0] exp_q[$];

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mrs_E (mrs_E),
    .mrt_E (mrt_E),
    .md_op (md_op),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    mrs_E = a;
    mrt_E = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Counts cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    mrs_E = 32'd0;
    mrt_E = 32'd0;

    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // mthi
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    // mult -1 * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // multu same operands
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu 7 / 2
    issue(3'd4, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // back-to-back mthi/mtlo preload
    issue(3'd5, 32'hAAAA_0000, 32'd0);
    issue(3'd6, 32'h5555_FFFF, 32'd0);
    chk("b2b_hi", hi, 32'hAAAA_0000);
    chk("b2b_lo", lo, 32'h5555_FFFF);

    // divide by zero leaves HI/LO untouched
    issue(3'd3, 32'd1234, 32'd0);
    chk("dz_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", hi, 32'hAAAA_0000);
    chk("dz_lo", lo, 32'h5555_FFFF);

    // signed overflow
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // requests while busy are ignored; operands changing mid-run too
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd0);
    issue(3'd1, 32'd3, 32'd5);
    @(posedge clk);
    #1;
    start = 1'b1;
    md_op = 3'd6;
    mrs_E = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    md_op = 3'd4;
    mrs_E = 32'd100;
    mrt_E = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
    wait_idle(n);
    chk("ign_cycles", 32'(n), 32'd2);
    chk("ign_lo", lo, exp_q.pop_front());
    chk("ign_hi", hi, exp_q.pop_front());
    @(posedge clk);
    #1;
    chk("ign_no_divu", {31'd0, busy}, 32'd0);
    chk("ign_lo_after", lo, 32'd15);

    // reset during a divide
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_hi", hi, 32'd0);
    chk("rmid_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rmid_late_busy", {31'd0, busy}, 32'd0);
    chk("rmid_late_hi", hi, 32'd0);
    chk("rmid_late_lo", lo, 32'd0);

    // next mult accepted normally
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    chk("post_cycles", 32'(n), 32'd5);
    chk("post_hi", hi, 32'd1);
    chk("post_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
